gate_exhaustive_checker: RTL and testbench

Self-checking stimulus/response engine that sits directly in front of and behind a 2-input logic gate (default: the team's NAND gate). It drives every input combination in order, waits a programmable settle time, samples the gate output and compares it against a parameterised truth table. At the end it reports pass/fail, an error count and a per-vector failure map. This replaces hand-written `#10` stimulus sequences with a reusable, synthesizable sequencer/checker.

---
 rtl/gate_chk_pkg.sv | 26 ++
 rtl/gate_settle_timer.sv | 30 +++
 rtl/gate_exhaustive_checker.sv | 111 +++++++++++
 tb/tb_gate_exhaustive_checker.sv | 236 +++++++++++++++++++++++
 4 files changed

// File: rtl/gate_chk_pkg.sv
// Shared types and constants for the exhaustive 2-input gate checker.
package gate_chk_pkg;

  typedef enum logic [1:0] {
    IDLE   = 2'd0,
    SETTLE = 2'd1,
    DONE   = 2'd2
  } state_t;

  localparam int NUM_VEC = 4;
  localparam int IDX_W   = 2;
  localparam int ERR_W   = 3;

  // Truth tables indexed by {a,b}; bit i is the expected y for index i.
  localparam logic [NUM_VEC-1:0] TT_NAND = 4'b0111;
  localparam logic [NUM_VEC-1:0] TT_AND  = 4'b1000;
  localparam logic [NUM_VEC-1:0] TT_OR   = 4'b1110;
  localparam logic [NUM_VEC-1:0] TT_XOR  = 4'b0110;
  localparam logic [NUM_VEC-1:0] TT_NOR  = 4'b0001;

  // True for the final vector of a sweep.
  function automatic logic is_last_vec(input logic [IDX_W-1:0] idx);
    return idx == IDX_W'(NUM_VEC - 1);
  endfunction

endpackage

// File: rtl/gate_settle_timer.sv
// Per-vector hold timer: expire marks the cycle a vector has been held
// for SETTLE_CYCLES+1 cycles and the gate output may be sampled.
module gate_settle_timer #(
  parameter int SETTLE_CYCLES = 2
) (
  input  logic clk,
  input  logic rst_n,
  input  logic clear,
  output logic expire
);

  localparam int CW = (SETTLE_CYCLES < 1) ? 1 : $clog2(SETTLE_CYCLES + 1);
  localparam logic [CW-1:0] LAST = CW'(SETTLE_CYCLES);

  logic [CW-1:0] cnt;

  assign expire = !clear && (cnt == LAST);

  // Count while running, restart at zero after each expiry or when cleared.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      cnt <= '0;
    end else if (clear || expire) begin
      cnt <= '0;
    end else begin
      cnt <= cnt + CW'(1);
    end
  end

endmodule

// File: rtl/gate_exhaustive_checker.sv
// Sequencer/checker that sweeps all four input vectors of a 2-input gate,
// samples its output after a settle time and records mismatches.
module gate_exhaustive_checker
  import gate_chk_pkg::*;
#(
  parameter int                 SETTLE_CYCLES = 2,
  parameter logic [NUM_VEC-1:0] TRUTH         = TT_NAND
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             start,
  output logic             a_o,
  output logic             b_o,
  input  logic             y_i,
  output logic             busy,
  output logic             done,
  output logic             pass,
  output logic [ERR_W-1:0] err_count,
  output logic [NUM_VEC-1:0] fail_vec
);

  state_t            state;
  state_t            state_next;
  logic [IDX_W-1:0]  idx;
  logic              expire;
  logic              sample;
  logic              mismatch;
  logic              last;
  logic [ERR_W-1:0]  err_next;

  gate_settle_timer #(
    .SETTLE_CYCLES(SETTLE_CYCLES)
  ) u_timer (
    .clk    (clk),
    .rst_n  (rst_n),
    .clear  (state != SETTLE),
    .expire (expire)
  );

  // The gate inputs are the registered vector index; idx returns to 0 at the end.
  assign a_o = idx[1];
  assign b_o = idx[0];

  assign sample   = (state == SETTLE) && expire;
  assign mismatch = (y_i != TRUTH[idx]);
  assign last     = is_last_vec(idx);
  assign err_next = err_count + {{(ERR_W-1){1'b0}}, mismatch};

  // State register.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state <= IDLE;
    end else begin
      state <= state_next;
    end
  end

  // Next-state: start only matters in IDLE, DONE lasts exactly one cycle.
  always_comb begin
    state_next = state;
    case (state)
      IDLE:    if (start) state_next = SETTLE;
      SETTLE:  if (sample && last) state_next = DONE;
      DONE:    state_next = IDLE;
      default: state_next = IDLE;
    endcase
  end

  // Status outputs decoded from the state.
  always_comb begin
    busy = (state == SETTLE);
    done = (state == DONE);
  end

  // Vector index and scoreboard: clear on accept, record on each sample.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      idx       <= '0;
      err_count <= '0;
      fail_vec  <= '0;
      pass      <= 1'b0;
    end else begin
      case (state)
        IDLE: begin
          if (start) begin
            idx       <= '0;
            err_count <= '0;
            fail_vec  <= '0;
            pass      <= 1'b0;
          end
        end
        SETTLE: begin
          if (sample) begin
            if (mismatch) begin
              fail_vec[idx] <= 1'b1;
            end
            err_count <= err_next;
            if (last) begin
              idx  <= '0;
              pass <= (err_next == '0);
            end else begin
              idx <= idx + IDX_W'(1);
            end
          end
        end
        default: ;
      endcase
    end
  end

endmodule

// File: tb/tb_gate_exhaustive_checker.sv
// Bench for gate_exhaustive_checker: a behavioural gate feeds y_i, a table of
// runs is applied with a scoreboard queue, plus hand sequences for
// held start and mid-run reset.
module tb_gate_exhaustive_checker;
  import gate_chk_pkg::*;

  localparam int S_A = 2;
  localparam int S_B = 0;

  localparam int G_NAND = 0;
  localparam int G_AND  = 1;
  localparam int G_OR   = 2;
  localparam int G_XOR  = 3;
  localparam int G_TIE1 = 4;
  localparam int G_TIE0 = 5;

  typedef struct {
    int dsel;
    int gate;
    int err;
    int fail;
    int pass;
    int restart_at;
  } vec_t;

  typedef struct {
    int lat;
    int err;
    int fail;
    int pass;
  } exp_t;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic       rst_n, start, start0;
  logic       a_o, b_o, y_i, busy, done, pass;
  logic [2:0] err_count;
  logic [3:0] fail_vec;
  logic       a_o0, b_o0, y_i0, busy0, done0, pass0;
  logic [2:0] err_count0;
  logic [3:0] fail_vec0;

  int gate_sel;
  int dsel_r;
  int n_checks = 0;
  int n_fail   = 0;
  exp_t sb[$];
  vec_t tbl[8];

  logic       obs_a, obs_b, obs_busy, obs_done, obs_pass;
  logic [2:0] obs_err;
  logic [3:0] obs_fail;

  gate_exhaustive_checker #(.SETTLE_CYCLES(S_A), .TRUTH(TT_NAND)) dut (
    .clk(clk), .rst_n(rst_n), .start(start), .a_o(a_o), .b_o(b_o), .y_i(y_i),
    .busy(busy), .done(done), .pass(pass), .err_count(err_count), .fail_vec(fail_vec)
  );

  gate_exhaustive_checker #(.SETTLE_CYCLES(S_B), .TRUTH(TT_XOR)) dut0 (
    .clk(clk), .rst_n(rst_n), .start(start0), .a_o(a_o0), .b_o(b_o0), .y_i(y_i0),
    .busy(busy0), .done(done0), .pass(pass0), .err_count(err_count0), .fail_vec(fail_vec0)
  );

  function automatic logic gate_fn(input int g, input logic a, input logic b);
    case (g)
      G_NAND:  return ~(a & b);
      G_AND:   return a & b;
      G_OR:    return a | b;
      G_XOR:   return a ^ b;
      G_TIE1:  return 1'b1;
      default: return 1'b0;
    endcase
  endfunction

  always_comb y_i  = gate_fn(gate_sel, a_o, b_o);
  always_comb y_i0 = gate_fn(gate_sel, a_o0, b_o0);

  always_comb begin
    if (dsel_r == 0) begin
      obs_a = a_o;   obs_b = b_o;   obs_busy = busy;   obs_done = done;
      obs_pass = pass;   obs_err = err_count;   obs_fail = fail_vec;
    end else begin
      obs_a = a_o0;  obs_b = b_o0;  obs_busy = busy0;  obs_done = done0;
      obs_pass = pass0;  obs_err = err_count0;  obs_fail = fail_vec0;
    end
  end

  task automatic check(input string name, input int act, input int exp);
    n_checks++;
    if (act != exp) begin
      n_fail++;
      $display("FAIL %s: got %0d expected %0d", name, act, exp);
    end
  endtask

  task automatic drive_start(input int dsel, input logic v);
    if (dsel == 0) start = v;
    else start0 = v;
  endtask

  task automatic run_vec(input vec_t v);
    exp_t e;
    int   s;
    int   c;
    bit   got;
    s        = (v.dsel == 0) ? S_A : S_B;
    dsel_r   = v.dsel;
    gate_sel = v.gate;
    e.lat = 4 * (s + 1);
    e.err = v.err;
    e.fail = v.fail;
    e.pass = v.pass;
    sb.push_back(e);
    drive_start(v.dsel, 1'b1);
    @(posedge clk); #1;
    drive_start(v.dsel, 1'b0);
    c = 0;
    got = 0;
    while (!got && c < 40) begin
      if (obs_done) begin
        got = 1;
        e = sb.pop_front();
        check("latency", c, e.lat);
        check("err_count", obs_err, e.err);
        check("fail_vec", obs_fail, e.fail);
        check("pass", obs_pass, e.pass);
        check("busy_at_done", obs_busy, 0);
      end else begin
        check("busy_run", obs_busy, 1);
        if (c < 4 * (s + 1)) check("ab_seq", {obs_a, obs_b}, c / (s + 1));
      end
      if (!got) begin
        drive_start(v.dsel, (c == v.restart_at));
        @(posedge clk); #1;
        c++;
      end
    end
    drive_start(v.dsel, 1'b0);
    if (!got) begin
      check("done_timeout", 0, 1);
      if (sb.size() > 0) void'(sb.pop_front());
    end
    @(posedge clk); #1;
    check("done_pulse", obs_done, 0);
    check("busy_idle", obs_busy, 0);
    check("pass_hold", obs_pass, e.pass);
    check("ab_idle", {obs_a, obs_b}, 0);
  endtask

  initial begin
    int c;
    rst_n = 1'b0; start = 1'b0; start0 = 1'b0; gate_sel = G_NAND; dsel_r = 0;

    tbl[0] = '{0, G_NAND, 0, 4'b0000, 1, -1};
    tbl[1] = '{0, G_TIE1, 1, 4'b1000, 0, -1};
    tbl[2] = '{0, G_AND,  4, 4'b1111, 0, -1};
    tbl[3] = '{0, G_TIE0, 3, 4'b0111, 0, -1};
    tbl[4] = '{0, G_OR,   2, 4'b1001, 0, -1};
    tbl[5] = '{0, G_NAND, 0, 4'b0000, 1, 5};
    tbl[6] = '{1, G_XOR,  0, 4'b0000, 1, -1};
    tbl[7] = '{1, G_AND,  3, 4'b1110, 0, -1};

    repeat (2) @(posedge clk);
    #1;
    check("rst_ab", {a_o, b_o}, 0);
    check("rst_busy", busy, 0);
    check("rst_done", done, 0);
    check("rst_pass", pass, 0);
    check("rst_err", err_count, 0);
    check("rst_fail", fail_vec, 0);
    check("rst_busy0", busy0, 0);
    @(negedge clk) rst_n = 1'b1;
    @(posedge clk); #1;

    for (int i = 0; i < 8; i++) run_vec(tbl[i]);

    // Start held high: second run accepted on the IDLE edge after DONE.
    dsel_r = 0;
    gate_sel = G_TIE1;
    start = 1'b1;
    @(posedge clk); #1;
    c = 0;
    while (!done && c < 40) begin
      @(posedge clk); #1;
      c++;
    end
    check("held_latency", c, 12);
    check("held_err", err_count, 1);
    check("held_fail", fail_vec, 4'b1000);
    gate_sel = G_NAND;
    @(posedge clk); #1;
    check("held_idle_busy", busy, 0);
    @(posedge clk); #1;
    check("held_rearm_busy", busy, 1);
    check("held_clear_err", err_count, 0);
    check("held_clear_fail", fail_vec, 0);
    check("held_clear_pass", pass, 0);
    start = 1'b0;
    c = 0;
    while (!done && c < 40) begin
      @(posedge clk); #1;
      c++;
    end
    check("held2_latency", c, 12);
    check("held2_pass", pass, 1);
    repeat (2) @(posedge clk);
    #1;

    // Asynchronous reset during vector 2.
    gate_sel = G_TIE1;
    start = 1'b1;
    @(posedge clk); #1;
    start = 1'b0;
    repeat (7) @(posedge clk);
    #1;
    check("pre_rst_ab", {a_o, b_o}, 2);
    check("pre_rst_busy", busy, 1);
    @(negedge clk) rst_n = 1'b0;
    #1;
    check("arst_ab", {a_o, b_o}, 0);
    check("arst_busy", busy, 0);
    check("arst_done", done, 0);
    check("arst_pass", pass, 0);
    check("arst_err", err_count, 0);
    check("arst_fail", fail_vec, 0);
    repeat (2) @(negedge clk);
    rst_n = 1'b1;
    @(posedge clk); #1;
    run_vec(tbl[0]);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
